hseq_source: RTL and testbench

Parametrised message source for the hgen_net fabric. It is the driving counterpart of the null source: where that block only initialises an idle output channel, this block emits a programmable sequence of messages on its output channel. Payloads are arithmetic progressions; inter-message gaps and message count are configurable, and an enable input gates emission. It is used as a traffic generator in net test benches and as a boot-time message injector in generated designs.

---
 rtl/hseq_source.sv | 107 ++++++++++
 tb/tb_hseq_source.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/hseq_source.sv
// hseq_source: programmable two-phase message source emitting arithmetic-progression payloads
// with configurable inter-message gap, message count and an emission enable.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module hseq_source #(
    parameter int unsigned MY_LOCAL_ADDR = 0,
    parameter int unsigned DST_ADDR      = 0,
    parameter int          ASZ           = `NS_ADDRESS_SIZE,
    parameter int          DSZ           = `NS_DATA_SIZE,
    parameter int          RSZ           = `NS_REDUN_SIZE,
    parameter int unsigned NUM_MSGS      = 4,
    parameter int unsigned START_DATA    = 0,
    parameter int unsigned STEP          = 1,
    parameter int unsigned GAP           = 0,
    parameter int          CSZ           = 16
) (
    input  logic           gch_clk,
    input  logic           gch_reset,
    output logic           gch_ready,
    input  logic           src_go,
    output logic           snd0_req_out,
    input  logic           snd0_ack_in,
    output logic [ASZ-1:0] snd0_src,
    output logic [ASZ-1:0] snd0_dst,
    output logic [DSZ-1:0] snd0_dat,
    output logic [RSZ-1:0] snd0_red,
    output logic [CSZ-1:0] src_count,
    output logic           src_done
);
    localparam int GW = $clog2(GAP + 2);
    localparam int SW = ASZ > DSZ ? ASZ : DSZ;

    typedef enum logic [1:0] {S_INIT, S_GAP, S_WAIT, S_DONE} state_t;

    state_t         state;
    logic [GW-1:0]  gap_cnt;
    logic [DSZ-1:0] next_dat;
    logic [SW-1:0]  sum;
    logic [CSZ-1:0] count_inc;
    logic           gap_full;

    // Redundancy only depends on the low bits, so summing at the wider field width is exact.
    always_comb begin
        sum       = SW'(ASZ'(MY_LOCAL_ADDR)) + SW'(ASZ'(DST_ADDR)) + SW'(next_dat);
        count_inc = src_count + 1'b1;
        gap_full  = gap_cnt == GW'(GAP);
    end

    always_ff @(posedge gch_clk) begin
        if (gch_reset) begin
            state        <= S_INIT;
            gch_ready    <= 1'b0;
            snd0_req_out <= 1'b0;
            snd0_src     <= '0;
            snd0_dst     <= '0;
            snd0_dat     <= '0;
            snd0_red     <= '0;
            src_count    <= '0;
            src_done     <= 1'b0;
            gap_cnt      <= '0;
            next_dat     <= '0;
        end else begin
            case (state)
                S_INIT: begin
                    state     <= S_GAP;
                    gch_ready <= 1'b1;
                    gap_cnt   <= '0;
                    next_dat  <= DSZ'(START_DATA);
                end
                S_GAP: begin
                    if (gap_full && src_go) begin
                        snd0_src     <= ASZ'(MY_LOCAL_ADDR);
                        snd0_dst     <= ASZ'(DST_ADDR);
                        snd0_dat     <= next_dat;
                        snd0_red     <= sum[RSZ-1:0];
                        snd0_req_out <= ~snd0_req_out;
                        state        <= S_WAIT;
                    end else if (!gap_full) begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (snd0_ack_in == snd0_req_out) begin
                        src_count <= count_inc;
                        next_dat  <= next_dat + DSZ'(STEP);
                        if (NUM_MSGS != 0 && count_inc == CSZ'(NUM_MSGS)) begin
                            state    <= S_DONE;
                            src_done <= 1'b1;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hseq_source.sv
// tb_hseq_source: randomized receiver driving two hseq_source configurations (bounded, and
// unbounded with wrap and gap) against a closed-form model of the message sequence.
module tb_hseq_source;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic go [2];
    logic ack [2];
    bit   sel;
    int   checks = 0;
    int   passes = 0;
    bit   timed;

    int unsigned p_src   [2] = '{3, 7};
    int unsigned p_dst   [2] = '{9, 200};
    int unsigned p_num   [2] = '{4, 0};
    int unsigned p_start [2] = '{5, 250};
    int unsigned p_step  [2] = '{3, 4};
    int unsigned p_gap   [2] = '{0, 3};
    int unsigned p_cmask [2] = '{15, 3};
    int unsigned kk      [2];

    logic       a_ready, a_req, a_done, b_ready, b_req, b_done;
    logic [7:0] a_src, a_dst, a_dat, b_src, b_dst, b_dat;
    logic [3:0] a_red, b_red, a_cnt;
    logic [1:0] b_cnt;
    logic [31:0] v_req, v_src, v_dst, v_dat, v_red, v_cnt, v_done;

    always #5 clk = ~clk;

    hseq_source #(.MY_LOCAL_ADDR(3), .DST_ADDR(9), .ASZ(8), .DSZ(8), .RSZ(4), .NUM_MSGS(4),
                  .START_DATA(5), .STEP(3), .GAP(0), .CSZ(4)) dut_a (
        .gch_clk(clk), .gch_reset(rst), .gch_ready(a_ready), .src_go(go[0]),
        .snd0_req_out(a_req), .snd0_ack_in(ack[0]), .snd0_src(a_src), .snd0_dst(a_dst),
        .snd0_dat(a_dat), .snd0_red(a_red), .src_count(a_cnt), .src_done(a_done));

    hseq_source #(.MY_LOCAL_ADDR(7), .DST_ADDR(200), .ASZ(8), .DSZ(8), .RSZ(4), .NUM_MSGS(0),
                  .START_DATA(250), .STEP(4), .GAP(3), .CSZ(2)) dut_b (
        .gch_clk(clk), .gch_reset(rst), .gch_ready(b_ready), .src_go(go[1]),
        .snd0_req_out(b_req), .snd0_ack_in(ack[1]), .snd0_src(b_src), .snd0_dst(b_dst),
        .snd0_dat(b_dat), .snd0_red(b_red), .src_count(b_cnt), .src_done(b_done));

    always_comb begin
        v_req  = sel ? 32'(b_req)  : 32'(a_req);
        v_src  = sel ? 32'(b_src)  : 32'(a_src);
        v_dst  = sel ? 32'(b_dst)  : 32'(a_dst);
        v_dat  = sel ? 32'(b_dat)  : 32'(a_dat);
        v_red  = sel ? 32'(b_red)  : 32'(a_red);
        v_cnt  = sel ? 32'(b_cnt)  : 32'(a_cnt);
        v_done = sel ? 32'(b_done) : 32'(a_done);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else passes++;
    endtask

    function automatic logic [31:0] exp_dat(input int unsigned k);
        return (p_start[sel] + k * p_step[sel]) & 32'hFF;
    endfunction

    task automatic wait_pending(output int w, output bit hit);
        hit = 0;
        w = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            w++;
            hit = v_req != 32'(ack[sel]);
        end
    endtask

    // One message: find it, check its fields, hold it for `delay` cycles, then accept it.
    task automatic serve(input int delay, input bit bp);
        int w;
        bit hit;
        logic [31:0] d;
        wait_pending(w, hit);
        check("pending", 32'(hit), 1);
        if (timed) check("gap_timing", w, p_gap[sel] + 1);
        d = exp_dat(kk[sel]);
        check("dat", v_dat, d);
        check("src", v_src, p_src[sel]);
        check("dst", v_dst, p_dst[sel]);
        check("red", v_red, (p_src[sel] + p_dst[sel] + d) & 15);
        check("count_pre", v_cnt, kk[sel] & p_cmask[sel]);
        for (int i = 0; i < delay; i++) begin
            if (bp) go[sel] = 1'b0;
            @(negedge clk);
            check("hold_dat", v_dat, d);
            check("hold_pending", 32'(v_req != 32'(ack[sel])), 1);
        end
        ack[sel] = ~ack[sel];
        @(negedge clk);
        kk[sel]++;
        check("count", v_cnt, kk[sel] & p_cmask[sel]);
        check("done", v_done, 32'(p_num[sel] != 0 && kk[sel] == p_num[sel]));
        timed = !bp;
        if (bp) begin
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check("no_req_nogo", v_req, 32'(ack[sel]));
            end
            go[sel] = 1'b1;
        end
    endtask

    initial begin
        int w;
        bit hit;
        go[0] = 1'b0; go[1] = 1'b0; ack[0] = 1'b0; ack[1] = 1'b0;
        sel = 1'b0; timed = 1'b0; kk[0] = 0; kk[1] = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_a", {a_ready, a_req, a_src, a_dst, a_dat, a_red, a_cnt, a_done}, 0);
            check("rst_b", {b_ready, b_req, b_src, b_dst, b_dat, b_red, b_cnt, b_done}, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_a", 32'(a_ready), 1);
        check("ready_b", 32'(b_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle_req", {a_req, b_req}, 0);
        end
        // Bounded source with back-pressure on the third message.
        go[0] = 1'b1;
        for (int m = 0; m < 4; m++) serve(m == 2 ? 10 : int'($urandom_range(0, 2)), m == 2);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("done_quiet", {a_req, a_done, a_cnt}, {ack[0], 1'b1, 4'd4});
        end
        go[0] = 1'b0;
        // Unbounded source: data and count wrap, gap of 3.
        sel = 1'b1; timed = 1'b0;
        go[1] = 1'b1;
        for (int m = 0; m < 6; m++) serve(m < 2 ? 0 : int'($urandom_range(0, 4)), 1'b0);
        wait_pending(w, hit);
        check("pending_pre_rst", 32'(hit), 1);
        rst = 1'b1;
        ack[0] = 1'b0; ack[1] = 1'b0;
        @(negedge clk);
        check("mid_rst", {b_ready, b_req, b_dat, b_cnt, b_done}, 0);
        rst = 1'b0;
        kk[0] = 0; kk[1] = 0; timed = 1'b0;
        @(negedge clk);
        check("ready_again", 32'(b_ready), 1);
        for (int m = 0; m < 3; m++) serve(int'($urandom_range(0, 3)), 1'b0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
